// File: rtl/vmac_pkg.sv
// Shared types and constants for the vector_mac dot-product stage.
package vmac_pkg;

   localparam int DATA_W = 8;
   localparam int NIB_W  = 4;
   localparam int ACC_W  = 2 * DATA_W + NIB_W;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [NIB_W-1:0]  nibble_t;
   typedef logic [ACC_W-1:0]  acc_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      POP   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } vmac_state_e;

   // Unsigned DATA_W x DATA_W product, zero-extended to the accumulator width.
   function automatic acc_t mac_term(input data_t a, input data_t b);
      logic [2*DATA_W-1:0] prod;
      prod = a * b;
      return {{(ACC_W - 2 * DATA_W){1'b0}}, prod};
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered multiply-accumulate; clear has priority over enable.
module mac_unit
   import vmac_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  clr_i,
   input  logic  en_i,
   input  data_t a_i,
   input  data_t b_i,
   output acc_t  acc_o
);

   acc_t acc_q;
   acc_t acc_d;

   // Next accumulator value: clear on a new dot product, add one term per valid beat.
   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = {ACC_W{1'b0}};
      end else if (en_i) begin
         acc_d = acc_q + mac_term(a_i, b_i);
      end else begin
         acc_d = acc_q;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= {ACC_W{1'b0}};
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/vector_mac.sv
// Dot-product stage: pops N vector/row elements in lockstep, accumulates
// their products and emits one result per row, re-arming fifo_vector via clr.
module vector_mac
   import vmac_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    start,
   input  nibble_t N,
   input  logic    vec_ready,
   input  data_t   vec_data,
   input  data_t   row_data,
   output logic    vec_pop,
   output logic    row_pop,
   output logic    clr,
   output logic    busy,
   output acc_t    result,
   output logic    result_valid
);

   vmac_state_e state_q, state_d;
   nibble_t     n_q, n_d;
   nibble_t     cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        pop_q, pop_d;
   logic        rd_vld_q;
   acc_t        result_q, result_d;
   logic        rv_q, rv_d;
   logic        clr_q, clr_d;
   logic        acc_clr_s;
   acc_t        acc_s;

   // Next-state and output decode for the pop/drain/done sequence.
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      result_d  = result_q;
      rv_d      = 1'b0;
      clr_d     = 1'b0;
      acc_clr_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && vec_ready) begin
               n_d       = N;
               cnt_d     = {NIB_W{1'b0}};
               busy_d    = 1'b1;
               acc_clr_s = 1'b1;
               if (N != {NIB_W{1'b0}}) begin
                  state_d = POP;
               end else begin
                  state_d = DONE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         POP: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == (n_q - 4'd1)) begin
               state_d = DRAIN;
            end else begin
               state_d = POP;
            end
         end
         DRAIN: begin
            // last data beat lands in the accumulator this cycle
            state_d = DONE;
         end
         DONE: begin
            result_d = acc_s;
            rv_d     = 1'b1;
            clr_d    = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      pop_d = (state_d == POP);
   end

   // Control and output registers; reset aborts any run without a result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         n_q      <= {NIB_W{1'b0}};
         cnt_q    <= {NIB_W{1'b0}};
         busy_q   <= 1'b0;
         pop_q    <= 1'b0;
         rd_vld_q <= 1'b0;
         result_q <= {ACC_W{1'b0}};
         rv_q     <= 1'b0;
         clr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         pop_q    <= pop_d;
         rd_vld_q <= pop_q;
         result_q <= result_d;
         rv_q     <= rv_d;
         clr_q    <= clr_d;
      end
   end

   mac_unit u_mac (
      .clk_i  (clk),
      .rst_ni (rst),
      .clr_i  (acc_clr_s),
      .en_i   (rd_vld_q),
      .a_i    (vec_data),
      .b_i    (row_data),
      .acc_o  (acc_s)
   );

   assign vec_pop      = pop_q;
   assign row_pop      = pop_q;
   assign clr          = clr_q;
   assign busy         = busy_q;
   assign result       = result_q;
   assign result_valid = rv_q;

endmodule

// File: tb/tb_vector_mac.sv
// Directed bench for vector_mac with behavioural vector/row FIFO models.
module tb_vector_mac;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  N = 4'd0;
   logic        vec_ready = 1'b0;
   logic [7:0]  vec_data;
   logic [7:0]  row_data;
   logic        vec_pop, row_pop, clr, busy, result_valid;
   logic [19:0] result;

   int tests = 0;
   int failed = 0;
   int cyc = 0;
   int pop_cnt = 0;
   int rv_cnt = 0;
   int lockstep_err = 0;
   int clr_err = 0;

   logic [7:0] vec_mem [0:63];
   logic [7:0] row_mem [0:63];
   int vec_idx;

   vector_mac dut (
      .clk(clk), .rst(rst), .start(start), .N(N), .vec_ready(vec_ready),
      .vec_data(vec_data), .row_data(row_data), .vec_pop(vec_pop),
      .row_pop(row_pop), .clr(clr), .busy(busy), .result(result),
      .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   // FIFO models: data valid one clock after a pop; pointers share rst.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         vec_idx  <= 0;
         vec_data <= 8'd0;
         row_data <= 8'd0;
      end else if (vec_pop) begin
         vec_data <= vec_mem[vec_idx];
         row_data <= row_mem[vec_idx];
         vec_idx  <= vec_idx + 1;
      end
   end

   // Event counters observed on every clock edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (vec_pop) pop_cnt <= pop_cnt + 1;
      if (result_valid) rv_cnt <= rv_cnt + 1;
      if (vec_pop !== row_pop) lockstep_err <= lockstep_err + 1;
      if (clr !== result_valid) clr_err <= clr_err + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic load(input int i, input logic [7:0] v, input logic [7:0] r);
      vec_mem[vec_idx + i] = v;
      row_mem[vec_idx + i] = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one start, then check latency, result, pulses and pop count.
   task automatic do_run(input string tag, input int n, input logic [31:0] exp_res);
      int  p0, t;
      bit  found;
      p0 = pop_cnt;
      found = 1'b0;
      N = n[3:0];
      start = 1'b1;
      tick();
      t = cyc;
      start = 1'b0;
      N = ~n[3:0];
      chk({tag, "_busy_set"}, busy, 1);
      for (int k = 0; k < 40; k++) begin
         if (!found) begin
            tick();
            if (result_valid) found = 1'b1;
         end
      end
      chk({tag, "_rv_seen"}, found, 1);
      if (found) begin
         chk({tag, "_latency"}, cyc - t - ((n == 0) ? 1 : n + 2) + 200, 200);
         chk({tag, "_result"}, result, exp_res);
         chk({tag, "_clr"}, clr, 1);
         chk({tag, "_busy_clr"}, busy, 0);
         chk({tag, "_pops"}, pop_cnt - p0, n);
         tick();
         chk({tag, "_rv_pulse"}, {result_valid, clr}, 0);
         tick();
         chk({tag, "_hold"}, result, exp_res);
      end
   endtask

   initial begin
      int p0, r0;
      bit reached;
      // 1: reset held with start asserted
      start = 1'b1;
      vec_ready = 1'b1;
      N = 4'd3;
      repeat (3) tick();
      chk("rst_outputs", {vec_pop, row_pop, clr, busy, result_valid, result}, 0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_idle", {busy, vec_pop, result_valid}, 0);
      chk("rst_no_pops", pop_cnt, 0);

      // 2: N=3, {1,2,3}.{4,5,6} = 32
      load(0, 8'd1, 8'd4); load(1, 8'd2, 8'd5); load(2, 8'd3, 8'd6);
      do_run("n3", 3, 32);

      // 3: N=15 all 255 -> 975375
      for (int i = 0; i < 15; i++) load(i, 8'd255, 8'd255);
      do_run("n15", 15, 975375);

      // 4: N=0 -> immediate zero result
      do_run("n0", 0, 0);

      // 5: start ignored while vec_ready low
      vec_ready = 1'b0;
      p0 = pop_cnt;
      N = 4'd2;
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      chk("nordy_busy", busy, 0);
      chk("nordy_pops", pop_cnt - p0, 0);
      vec_ready = 1'b1;
      load(0, 8'd2, 8'd4); load(1, 8'd3, 8'd5);
      do_run("rdy", 2, 23);

      // 6: reset after the second pop of an N=4 run
      load(0, 8'd9, 8'd9); load(1, 8'd9, 8'd9); load(2, 8'd9, 8'd9); load(3, 8'd9, 8'd9);
      p0 = pop_cnt;
      r0 = rv_cnt;
      N = 4'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      reached = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (!reached) begin
            tick();
            if (pop_cnt - p0 == 2) reached = 1'b1;
         end
      end
      chk("abort_reached", reached, 1);
      rst = 1'b0;
      #1;
      chk("abort_outputs", {vec_pop, row_pop, clr, busy, result_valid, result}, 0);
      repeat (2) tick();
      @(negedge clk);
      rst = 1'b1;
      repeat (4) tick();
      chk("abort_no_rv", rv_cnt - r0, 0);
      load(0, 8'd7, 8'd1); load(1, 8'd8, 8'd1);
      do_run("after", 2, 15);

      chk("lockstep", lockstep_err, 0);
      chk("clr_only_with_rv", clr_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
